instr_reg_reader: RTL and testbench

//  Read-side master for the 32-entry instruction register. On start, walks read_pointer over N entries

---
 rtl/instr_register_pkg.sv | 33 +++
 rtl/instr_reg_reader_if.sv | 32 +++
 rtl/instr_result_model.sv | 42 ++++
 rtl/instr_reg_reader.sv | 114 +++++++++++
 tb/tb_instr_reg_reader.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the 32-entry instruction register and its read-side reader.
package instr_register_pkg;

  localparam int DEPTH = 32;
  localparam int CNT_W = 6;
  localparam int OP_W  = 32;
  localparam int RES_W = 64;

  typedef logic signed [OP_W-1:0]  operand_t;
  typedef logic signed [RES_W-1:0] operand_result;
  typedef logic [4:0]              address_t;

  typedef enum logic [3:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  } opcode_t;

  typedef struct packed {
    opcode_t       opc;
    operand_t      op_a;
    operand_t      op_b;
    operand_result res;
  } instruction_t;

  typedef enum logic [1:0] {
    R_IDLE, R_FETCH, R_EMIT, R_DONE
  } reader_state_t;

  // Requests beyond the register depth read every entry exactly once.
  function automatic logic [CNT_W-1:0] clampCount(input logic [CNT_W-1:0] n);
    return (n > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : n;
  endfunction

endpackage

// File: rtl/instr_reg_reader_if.sv
// Control, register read port and checked-entry stream of the instruction register reader.
interface instr_reg_reader_if;
  import instr_register_pkg::*;

  logic               start;
  address_t           start_addr;
  logic [CNT_W-1:0]   num_instr;
  address_t           read_pointer;
  instruction_t       instruction_word;
  logic               out_valid;
  logic               out_ready;
  instruction_t       out_instr;
  operand_result      out_expected;
  logic               out_mismatch;
  logic               out_div0;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   err_count;

  modport master (
    input  start, start_addr, num_instr, instruction_word, out_ready,
    output read_pointer, out_valid, out_instr, out_expected, out_mismatch,
           out_div0, busy, done, err_count
  );

  modport slave (
    output start, start_addr, num_instr, instruction_word, out_ready,
    input  read_pointer, out_valid, out_instr, out_expected, out_mismatch,
           out_div0, busy, done, err_count
  );

endinterface

// File: rtl/instr_result_model.sv
// Combinational golden ALU: signed, full-width result for one instruction.
module instr_result_model
  import instr_register_pkg::*;
(
  input  opcode_t       opc_i,
  input  operand_t      opA_i,
  input  operand_t      opB_i,
  output operand_result expected_o,
  output logic          div0_o,
  output logic          illegal_o
);

  operand_result opA;
  operand_result opB;

  // Operands are sign-extended first so MULT keeps every product bit.
  always_comb begin
    opA        = {{(RES_W-OP_W){opA_i[OP_W-1]}}, opA_i};
    opB        = {{(RES_W-OP_W){opB_i[OP_W-1]}}, opB_i};
    expected_o = '0;
    div0_o     = 1'b0;
    illegal_o  = 1'b0;
    case (opc_i)
      ZERO:  expected_o = '0;
      PASSA: expected_o = opA;
      PASSB: expected_o = opB;
      ADD:   expected_o = opA + opB;
      SUB:   expected_o = opA - opB;
      MULT:  expected_o = opA * opB;
      DIV: begin
        if (opB == '0) div0_o = 1'b1;
        else           expected_o = opA / opB;
      end
      MOD: begin
        if (opB == '0) div0_o = 1'b1;
        else           expected_o = opA % opB;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_reg_reader.sv
// Read-side master: walks the instruction register from start_addr, checks each entry
// against the golden model and streams it out over a valid/ready handshake.
module instr_reg_reader
  import instr_register_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  instr_reg_reader_if.master  bus
);

  reader_state_t    state_q, state_d;
  address_t         readPointer_q, readPointer_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] errCount_q, errCount_d;
  logic             outValid_q, outValid_d;
  instruction_t     outInstr_q, outInstr_d;
  operand_result    outExpected_q, outExpected_d;
  logic             outMismatch_q, outMismatch_d;
  logic             outDiv0_q, outDiv0_d;

  operand_result    modelExpected;
  logic             modelDiv0;
  logic             modelIllegal;
  logic             entryMismatch;

  instr_result_model uModel (
    .opc_i      (bus.instruction_word.opc),
    .opA_i      (bus.instruction_word.op_a),
    .opB_i      (bus.instruction_word.op_b),
    .expected_o (modelExpected),
    .div0_o     (modelDiv0),
    .illegal_o  (modelIllegal)
  );

  // Case-equality so an X/Z result field is reported; div-by-zero results are not compared.
  assign entryMismatch = modelIllegal |
                         (!modelDiv0 && (bus.instruction_word.res !== modelExpected));

  always_comb begin
    state_d       = state_q;
    readPointer_d = readPointer_q;
    remaining_d   = remaining_q;
    errCount_d    = errCount_q;
    outValid_d    = outValid_q;
    outInstr_d    = outInstr_q;
    outExpected_d = outExpected_q;
    outMismatch_d = outMismatch_q;
    outDiv0_d     = outDiv0_q;
    case (state_q)
      R_IDLE: begin
        if (bus.start) begin
          readPointer_d = bus.start_addr;
          remaining_d   = clampCount(bus.num_instr);
          errCount_d    = '0;
          state_d       = (bus.num_instr == '0) ? R_DONE : R_FETCH;
        end
      end
      R_FETCH: begin
        outInstr_d    = bus.instruction_word;
        outExpected_d = modelExpected;
        outMismatch_d = entryMismatch;
        outDiv0_d     = modelDiv0;
        outValid_d    = 1'b1;
        state_d       = R_EMIT;
      end
      R_EMIT: begin
        if (bus.out_ready) begin
          outValid_d    = 1'b0;
          remaining_d   = remaining_q - 1'b1;
          readPointer_d = readPointer_q + address_t'(1);
          if (outMismatch_q && (errCount_q != '1)) errCount_d = errCount_q + 1'b1;
          state_d = (remaining_q == CNT_W'(1)) ? R_DONE : R_FETCH;
        end
      end
      R_DONE:  state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= R_IDLE;
      readPointer_q <= '0;
      remaining_q   <= '0;
      errCount_q    <= '0;
      outValid_q    <= 1'b0;
      outInstr_q    <= '{opc: ZERO, default: '0};
      outExpected_q <= '0;
      outMismatch_q <= 1'b0;
      outDiv0_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      readPointer_q <= readPointer_d;
      remaining_q   <= remaining_d;
      errCount_q    <= errCount_d;
      outValid_q    <= outValid_d;
      outInstr_q    <= outInstr_d;
      outExpected_q <= outExpected_d;
      outMismatch_q <= outMismatch_d;
      outDiv0_q     <= outDiv0_d;
    end
  end

  assign bus.read_pointer = readPointer_q;
  assign bus.out_valid    = outValid_q;
  assign bus.out_instr    = outInstr_q;
  assign bus.out_expected = outExpected_q;
  assign bus.out_mismatch = outMismatch_q;
  assign bus.out_div0     = outDiv0_q;
  assign bus.err_count    = errCount_q;
  assign bus.busy         = (state_q != R_IDLE);
  assign bus.done         = (state_q == R_DONE);

endmodule

// File: tb/tb_instr_reg_reader.sv
// Scoreboard bench for instr_reg_reader: directed bursts with hand-computed results.
module tb_instr_reg_reader;
  import instr_register_pkg::*;

  typedef struct {
    address_t      ptr;
    instruction_t  instr;
    operand_result expected;
    logic          mismatch;
    logic          div0;
  } sbItem_t;

  logic         clk;
  logic         reset_n;
  int           cyc;
  int           startCyc;
  int           checks;
  int           errors;
  int           lat;
  instruction_t regFile [DEPTH];
  sbItem_t      sbQueue [$];

  instr_reg_reader_if bus ();

  instr_reg_reader dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  assign bus.instruction_word = regFile[bus.read_pointer];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [159:0] actual,
                             input logic [159:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  function automatic instruction_t mkInstr(input opcode_t o, input operand_t a,
                                           input operand_t b, input operand_result r);
    instruction_t ins;
    ins.opc  = o;
    ins.op_a = a;
    ins.op_b = b;
    ins.res  = r;
    return ins;
  endfunction

  task automatic pushExp(input address_t ptr, input operand_result exp,
                         input logic mm, input logic d0);
    sbItem_t item;
    item.ptr      = ptr;
    item.instr    = regFile[ptr];
    item.expected = exp;
    item.mismatch = mm;
    item.div0     = d0;
    sbQueue.push_back(item);
  endtask

  task automatic applyStimulus(input address_t addr, input logic [CNT_W-1:0] n);
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.start_addr = addr;
    bus.num_instr  = n;
    @(posedge clk);
    #1;
    startCyc  = cyc;
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int latency);
    latency = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        latency = cyc - startCyc;
        break;
      end
    end
    if (latency < 0) checkOutput("done_timeout", 0, 1);
  endtask

  // Monitor: every accepted entry is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_transfer", {155'd0, bus.read_pointer}, 160'd0);
      end else begin
        sbItem_t item;
        item = sbQueue.pop_front();
        checkOutput("sb_ptr", bus.read_pointer, item.ptr);
        checkOutput("sb_instr", bus.out_instr, item.instr);
        checkOutput("sb_expected", bus.out_expected, item.expected);
        checkOutput("sb_mismatch", bus.out_mismatch, item.mismatch);
        checkOutput("sb_div0", bus.out_div0, item.div0);
      end
    end
  end

  initial begin
    cyc            = 0;
    checks         = 0;
    errors         = 0;
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.num_instr  = '0;
    bus.out_ready  = 1'b1;
    for (int i = 0; i < DEPTH; i++) regFile[i] = mkInstr(ZERO, 0, 0, 0);

    repeat (3) @(negedge clk);
    checkOutput("rst_ptr", bus.read_pointer, 0);
    checkOutput("rst_valid", bus.out_valid, 0);
    checkOutput("rst_instr", bus.out_instr, 0);
    checkOutput("rst_busy_done", {bus.busy, bus.done}, 0);
    checkOutput("rst_err", bus.err_count, 0);
    reset_n = 1'b1;

    // Basic burst: ADD, SUB, MULT with correct results.
    regFile[0] = mkInstr(ADD, 5, 7, 12);
    regFile[1] = mkInstr(SUB, 5, 7, -2);
    regFile[2] = mkInstr(MULT, -3, 4, -12);
    pushExp(0, 12, 0, 0);
    pushExp(1, -2, 0, 0);
    pushExp(2, -12, 0, 0);
    applyStimulus(0, 3);
    @(negedge clk);
    checkOutput("fetch_valid_low", bus.out_valid, 0);
    @(negedge clk);
    checkOutput("first_valid", bus.out_valid, 1);
    waitDone(20, lat);
    checkOutput("basic_done_lat", lat, 6);
    checkOutput("basic_err", bus.err_count, 0);
    @(negedge clk);
    checkOutput("done_one_cycle", bus.done, 0);

    // Wrap from entry 31 back to 0.
    regFile[30] = mkInstr(PASSA, 100, 5, 100);
    regFile[31] = mkInstr(PASSB, 100, -5, -5);
    pushExp(30, 100, 0, 0);
    pushExp(31, -5, 0, 0);
    pushExp(0, 12, 0, 0);
    pushExp(1, -2, 0, 0);
    applyStimulus(30, 4);
    waitDone(30, lat);
    checkOutput("wrap_done_lat", lat, 8);

    // Divide by zero and a corrupted result.
    regFile[4] = mkInstr(DIV, 9, 0, 77);
    regFile[5] = mkInstr(ADD, 1, 1, 3);
    pushExp(4, 0, 0, 1);
    pushExp(5, 2, 1, 0);
    applyStimulus(4, 2);
    waitDone(30, lat);
    checkOutput("div0_err", bus.err_count, 1);

    // Opcode outside the enumeration.
    regFile[8] = mkInstr(opcode_t'(4'd12), 3, 4, 0);
    pushExp(8, 0, 1, 0);
    applyStimulus(8, 1);
    waitDone(30, lat);
    checkOutput("illegal_err", bus.err_count, 1);

    // Back-pressure with a stray start in the stall window.
    regFile[6] = mkInstr(MOD, -7, 3, -1);
    regFile[7] = mkInstr(MULT, 100000, 100000, 64'sd10000000000);
    pushExp(6, -1, 0, 0);
    pushExp(7, 64'sd10000000000, 0, 0);
    bus.out_ready = 1'b0;
    applyStimulus(6, 2);
    for (int i = 0; i < 10 && !bus.out_valid; i++) @(negedge clk);
    checkOutput("stall_valid_seen", bus.out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      bus.start      = (c == 1);
      bus.start_addr = 20;
      bus.num_instr  = 3;
      @(negedge clk);
      checkOutput("stall_valid", bus.out_valid, 1);
      checkOutput("stall_ptr", bus.read_pointer, 6);
      checkOutput("stall_instr", bus.out_instr, regFile[6]);
      checkOutput("stall_expected", bus.out_expected, operand_result'(-1));
    end
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    waitDone(30, lat);
    repeat (3) @(negedge clk);
    checkOutput("stray_start_ignored", bus.busy, 0);

    // Empty burst.
    applyStimulus(0, 0);
    waitDone(5, lat);
    checkOutput("zero_done_lat", lat, 0);
    checkOutput("zero_busy", bus.busy, 1);
    checkOutput("zero_no_valid", bus.out_valid, 0);
    @(negedge clk);
    checkOutput("zero_idle", {bus.busy, bus.done}, 0);

    // Full-depth burst from 17, then an oversized request clamped to the depth.
    for (int i = 0; i < DEPTH; i++) regFile[i] = mkInstr(ADD, i, 2 * i, 3 * i);
    for (int k = 0; k < DEPTH; k++) pushExp(address_t'((17 + k) % DEPTH), 3 * ((17 + k) % DEPTH), 0, 0);
    applyStimulus(17, 32);
    waitDone(100, lat);
    checkOutput("full_done_lat", lat, 64);
    checkOutput("full_sb_empty", sbQueue.size(), 0);
    for (int k = 0; k < DEPTH; k++) pushExp(address_t'(k), 3 * k, 0, 0);
    applyStimulus(0, 40);
    waitDone(100, lat);
    checkOutput("clamp_done_lat", lat, 64);

    // Reset while the third of five entries is being emitted.
    regFile[1] = mkInstr(ADD, 1, 2, 999);
    pushExp(0, 0, 0, 0);
    pushExp(1, 3, 1, 0);
    pushExp(2, 6, 0, 0);
    applyStimulus(0, 5);
    for (int i = 0; i < 20 && !(bus.out_valid && bus.read_pointer == 2); i++) @(negedge clk);
    checkOutput("pre_reset_err", bus.err_count, 1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_ptr", bus.read_pointer, 0);
    checkOutput("abort_valid", bus.out_valid, 0);
    checkOutput("abort_instr", bus.out_instr, 0);
    checkOutput("abort_expected", bus.out_expected, 0);
    checkOutput("abort_flags", {bus.out_mismatch, bus.out_div0}, 0);
    checkOutput("abort_err", bus.err_count, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort_no_done", {bus.busy, bus.done}, 0);
    end
    checkOutput("abort_sb_empty", sbQueue.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, want finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
